// File: rtl/genetico_avaliador.sv
// Serial fitness evaluator for an evolved LE grid circuit.
// Walks every input vector column by column and counts output bits that match the target.
module genetico_avaliador #(
    parameter int ROW = 2,
    parameter int COL = 2,
    parameter int IN  = 2,
    parameter int OUT = 1,
    localparam int NLE    = ROW * COL,
    localparam int SEL_W  = $clog2(IN + NLE),
    localparam int OSEL_W = (NLE > 1) ? $clog2(NLE) : 1,
    localparam int NVEC   = 2 ** IN,
    localparam int FIT_W  = $clog2(OUT * NVEC + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NLE*16-1:0]         saidas_LE,
    input  logic [NLE*4*SEL_W-1:0]    in_chrom,
    input  logic [OUT*OSEL_W-1:0]     out_chrom,
    input  logic [OUT*NVEC-1:0]       target,
    output logic                      busy,
    output logic                      done,
    output logic [FIT_W-1:0]          fitness
);

    localparam int CW = (COL > 1) ? $clog2(COL) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVAL = 2'd1;
    localparam logic [1:0] S_CMP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]               state;
    logic [NLE*16-1:0]        truth_r;
    logic [NLE*4*SEL_W-1:0]   sel_r;
    logic [OUT*OSEL_W-1:0]    osel_r;
    logic [OUT*NVEC-1:0]      tgt_r;
    logic [NLE-1:0]           le_out;
    logic [NLE-1:0]           le_next;
    logic [CW-1:0]            c_cnt;
    logic [IN-1:0]            v_cnt;
    logic [FIT_W-1:0]         acc;
    logic [FIT_W-1:0]         match_cnt;
    logic [OUT-1:0]           circ_out;
    logic [OUT-1:0]           tgt_v;

    // Slot source: circuit input, an earlier-column LE, or constant 0.
    function automatic logic sig_val(
        input logic [SEL_W-1:0] s,
        input int               lim,
        input logic [IN-1:0]    vec,
        input logic [NLE-1:0]   les
    );
        logic r;
        r = 1'b0;
        for (int i = 0; i < IN; i++)
            if (s == SEL_W'(i)) r = vec[i];
        for (int m = 0; m < NLE; m++)
            if (s == SEL_W'(IN + m) && (IN + m) < lim) r = les[m];
        return r;
    endfunction

    // Output source: the selected LE, or 0 for an out-of-range index.
    function automatic logic out_sel(
        input logic [OSEL_W-1:0] os,
        input logic [NLE-1:0]    les
    );
        logic r;
        r = 1'b0;
        for (int m = 0; m < NLE; m++)
            if (os == OSEL_W'(m)) r = les[m];
        return r;
    endfunction

    for (genvar n = 0; n < NLE; n++) begin : g_le
        localparam int LIM = IN + (n / ROW) * ROW;
        logic [3:0]  idx;
        logic [15:0] tt;
        for (genvar j = 0; j < 4; j++) begin : g_slot
            assign idx[j] = sig_val(sel_r[(n*4+j)*SEL_W +: SEL_W],
                                    LIM, v_cnt, le_out);
        end
        assign tt         = truth_r[n*16 +: 16];
        assign le_next[n] = tt[idx];
    end

    for (genvar k = 0; k < OUT; k++) begin : g_out
        assign circ_out[k] = out_sel(osel_r[k*OSEL_W +: OSEL_W], le_out);
    end

    // Target bits belonging to the current input vector.
    always_comb begin
        tgt_v = '0;
        for (int vv = 0; vv < NVEC; vv++)
            if (v_cnt == IN'(vv)) tgt_v = tgt_r[vv*OUT +: OUT];
    end

    // Number of circuit outputs agreeing with the target for this vector.
    always_comb begin
        match_cnt = '0;
        for (int k = 0; k < OUT; k++)
            if (circ_out[k] == tgt_v[k]) match_cnt = match_cnt + FIT_W'(1);
    end

    assign busy = (state != S_IDLE);

    // Control FSM, operand capture, LE result registers and scoring.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            done    <= 1'b0;
            fitness <= '0;
            acc     <= '0;
            c_cnt   <= '0;
            v_cnt   <= '0;
            le_out  <= '0;
            truth_r <= '0;
            sel_r   <= '0;
            osel_r  <= '0;
            tgt_r   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        truth_r <= saidas_LE;
                        sel_r   <= in_chrom;
                        osel_r  <= out_chrom;
                        tgt_r   <= target;
                        c_cnt   <= '0;
                        v_cnt   <= '0;
                        acc     <= '0;
                        state   <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    for (int n = 0; n < NLE; n++)
                        if (int'(c_cnt) == n / ROW) le_out[n] <= le_next[n];
                    if (c_cnt == CW'(COL - 1)) begin
                        state <= S_CMP;
                    end else begin
                        c_cnt <= c_cnt + CW'(1);
                    end
                end
                S_CMP: begin
                    acc <= acc + match_cnt;
                    if (v_cnt == IN'(NVEC - 1)) begin
                        state <= S_DONE;
                    end else begin
                        v_cnt <= v_cnt + IN'(1);
                        c_cnt <= '0;
                        state <= S_EVAL;
                    end
                end
                S_DONE: begin
                    done    <= 1'b1;
                    fitness <= acc;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_genetico_avaliador.sv
// Directed bench for genetico_avaliador at ROW=2, COL=2, IN=2, OUT=1.
// Expected fitness values are worked out by hand from the truth tables.
module tb_genetico_avaliador;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] saidas_LE;
    logic [47:0] in_chrom;
    logic [1:0]  out_chrom;
    logic [3:0]  target;
    logic        busy;
    logic        done;
    logic [2:0]  fitness;

    int n_vec;
    int n_err;

    genetico_avaliador #(
        .ROW(2), .COL(2), .IN(2), .OUT(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .saidas_LE (saidas_LE),
        .in_chrom  (in_chrom),
        .out_chrom (out_chrom),
        .target    (target),
        .busy      (busy),
        .done      (done),
        .fitness   (fitness)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_circuit();
        saidas_LE = '0;
        in_chrom  = '0;
        out_chrom = '0;
        target    = '0;
    endtask

    task automatic set_sel(input int n, input int j, input logic [2:0] s);
        in_chrom[(n*4+j)*3 +: 3] = s;
    endtask

    task automatic set_le(input int n, input logic [15:0] t);
        saidas_LE[n*16 +: 16] = t;
    endtask

    // LE0 = x0 & x1 via slots {x0,x1,x0,x0}
    task automatic load_and();
        clear_circuit();
        set_le(0, 16'h8888);
        set_sel(0, 0, 3'd0);
        set_sel(0, 1, 3'd1);
        set_sel(0, 2, 3'd0);
        set_sel(0, 3, 3'd0);
    endtask

    // Start one run and watch a fixed 40-cycle window for done pulses.
    task automatic run(input string tag, input int exp_fit,
                       input int poke, input logic [3:0] poke_tgt);
        int n;
        int dones;
        int done_at;
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, ".busy_rise"}, busy, 1);
        n = 0;
        dones = 0;
        done_at = -1;
        while (n < 40) begin
            if (n == poke) begin
                start  = 1'b1;
                target = poke_tgt;
            end
            step();
            start = 1'b0;
            n++;
            if (done) begin
                dones++;
                if (done_at < 0) begin
                    done_at = n;
                    check({tag, ".fitness"}, fitness, exp_fit);
                    check({tag, ".busy_at_done"}, busy, 0);
                end
            end
        end
        check({tag, ".latency"}, done_at, 13);
        check({tag, ".done_count"}, dones, 1);
        check({tag, ".fitness_hold"}, fitness, exp_fit);
    endtask

    initial begin
        int dones;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        clear_circuit();
        repeat (3) step();
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.fitness", fitness, 0);
        rst = 1'b0;
        step();

        load_and();
        target = 4'b1000;
        run("and", 4, -1, 4'b0);

        target = 4'b0110;
        run("xor_target", 1, -1, 4'b0);

        clear_circuit();
        set_le(0, 16'hAAAA);
        set_sel(0, 0, 3'd2);
        target = 4'b0000;
        run("self_loop_zero", 4, -1, 4'b0);

        target = 4'b1111;
        run("self_loop_ones", 0, -1, 4'b0);

        load_and();
        for (int j = 0; j < 4; j++) set_sel(2, j, 3'd2);
        set_le(2, 16'hFFFF);
        out_chrom = 2'd2;
        target    = 4'b1111;
        run("col2_const1", 4, -1, 4'b0);

        out_chrom = 2'd3;
        run("col2_le3_zero", 0, -1, 4'b0);

        set_le(2, 16'h8000);
        out_chrom = 2'd2;
        target    = 4'b1000;
        run("col2_copy_and", 4, -1, 4'b0);

        target = 4'b1111;
        run("col2_copy_ones", 1, -1, 4'b0);

        load_and();
        target = 4'b1000;
        run("start_busy", 4, 5, 4'b0110);

        load_and();
        target = 4'b0110;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst.busy", busy, 0);
        check("midrst.fitness", fitness, 0);
        check("midrst.done", done, 0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) dones++;
        end
        check("midrst.no_done", dones, 0);

        target = 4'b1000;
        run("after_rst", 4, -1, 4'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/genetico_avaliador.md
GENETICO_AVALIADOR -- requirements
Module: genetico_avaliador

Interface
- REQ-001 SHALL have parameter ROW, default 2: logic-element (LE) rows.
- REQ-002 SHALL have parameter COL, default 2: LE columns, evaluated left to right.
- REQ-003 SHALL have parameter IN, default 2, range 1..8: circuit inputs.
- REQ-004 SHALL have parameter OUT, default 1: circuit outputs.
- REQ-005 SHALL derive the following: NLE = ROW*COL; SEL_W = clog2(IN+NLE); OSEL_W = clog2(NLE); NVEC = 2**IN; FIT_W = clog2(OUT*NVEC+1).
- REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-008 SHALL have port start, input, 1 bit: request an evaluation.
- REQ-009 SHALL have port saidas_LE, input, NLE*16 bits: truth table of LE n in bits [n*16 +: 16].
- REQ-010 SHALL have port in_chrom, input, NLE*4*SEL_W bits: for LE n, input slot j selector in bits [(n*4+j)*SEL_W +: SEL_W].
- REQ-011 SHALL have port out_chrom, input, OUT*OSEL_W bits: LE index driving circuit output k.
- REQ-012 SHALL have port target, input, OUT*NVEC bits: expected output k for input vector v, at bit v*OUT+k.
- REQ-013 SHALL have port busy, output, 1 bit: an evaluation is in progress.
- REQ-014 SHALL have port done, output, 1 bit: one-cycle completion pulse.
- REQ-015 SHALL have port fitness, output, FIT_W bits: count of matching output bits.

Function
- REQ-016 SHALL index LEs column-major: n = col*ROW + row.
- REQ-017 SHALL compute each LE output as truth[{s3,s2,s1,s0}], where sj is the signal picked by slot j.
- REQ-018 SHALL map selector values as follows:
  - 0..IN-1 → circuit input bit sel of the current vector v;
  - IN+m → output of LE m;
  - any selector ≥ IN+col*ROW for an LE in column col (not feed-forward), or ≥ IN+NLE → constant 0.
- REQ-019 SHALL drive circuit output k from LE out_chrom[k]; a selector ≥ NLE → constant 0.
- REQ-020 SHALL, on start=1 in IDLE, capture saidas_LE, in_chrom, out_chrom and target into internal registers; input changes afterwards do not affect the run.
- REQ-021 SHALL implement the FSM with states IDLE, EVAL, CMP, DONE:
  - IDLE→EVAL on start; v=0, column counter c=0, accumulator=0.
  - EVAL: each cycle, registers the outputs of all ROW LEs of column c; after c=COL-1 goes to CMP, else c++.
  - CMP (one cycle): adds to the accumulator the number of k where output k equals target[v*OUT+k]. If v=NVEC-1 goes to DONE; else v++, c=0, back to EVAL.
  - DONE (one cycle): done=1, fitness loaded from the accumulator, then IDLE.
- REQ-022 SHALL evaluate serially: column c reads only column<c LE results registered earlier for the same v.
- REQ-023 SHALL have a latency of NVEC*(COL+1)+1 cycles from the start-accept edge to the cycle where done=1.
- REQ-024 SHALL assert busy in EVAL, CMP and DONE, and deassert it in IDLE.
- REQ-025 SHALL ignore start while busy=1, with no restart and no queueing.
- REQ-026 SHALL accept a start in the cycle after DONE.
- REQ-027 SHALL hold fitness from the DONE cycle until the next DONE.
- REQ-028 SHALL size the accumulator at FIT_W bits; the full score OUT*NVEC SHALL be representable without wrap.

Reset
- REQ-029 SHALL, when rst=1 at a clock edge, force state=IDLE, busy=0, done=0, fitness=0, and clear the accumulator and counters.
- REQ-030 SHALL abort any run on reset mid-operation, with no done pulse.
- REQ-031 SHALL give rst priority over start in the same cycle.

Verification (ROW=2, COL=2, IN=2, OUT=1)
- REQ-032 SHALL cover AND: LE0 slots {x0,x1,x0,x0}, truth 16'h8888, out_chrom=0, target=4'b1000, start.
  - Response: busy rises the next cycle.
  - done=1 exactly 13 cycles after the accept edge, fitness=4.
- REQ-033 SHALL cover mismatch: same circuit, target=4'b0110 (XOR) → fitness=1.
- REQ-034 SHALL cover feed-forward: LE0 slot0 selector=2 (LE0 itself, illegal), truth 16'hAAAA, target=4'b0000 → output constant 0, fitness=4.
- REQ-035 SHALL cover a second column: LE2 slots all = 2 (LE0), truth 16'hFFFF, out_chrom=2, target=4'b1111 → fitness=4.
  - With out_chrom=3 (LE3 truth 0) instead → fitness=0.
- REQ-036 SHALL cover start while busy: pulse start again at cycle 5 → a single done at cycle 13, fitness unchanged.
  - Also: change target mid-run → result unchanged.
- REQ-037 SHALL cover reset: assert rst at cycle 6 of a run → busy=0, fitness=0, no done.
  - Then a new start → done 13 cycles later with the correct fitness.
